state_serializer: RTL

Output-side counterpart to the AES input unpacker. Accepts a completed AES state (4×4 byte array, indexed [row][col]) from the core and does two things:
- Flattens it back into the 128-bit column-major block image.
- Streams that image out one byte at a time over a valid/ready handshake toward the SPI/MCU return path.

It sits between the AES core's done/result and the serial output logic.

---
 rtl/state_serializer.sv | 89 ++++++++
 1 files changed

// File: rtl/state_serializer.sv
// state_serializer: flattens a finished AES state into its column-major 128-bit
// image and streams that image out one byte per valid/ready transfer.
module state_serializer #(
  parameter int unsigned REVERSE_ORDER = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   state_valid,
  input  logic [0:3][0:3][7:0]   state_in,
  output logic                   state_ready,
  output logic [127:0]           flat_out,
  output logic                   byte_valid,
  output logic [7:0]             byte_data,
  output logic                   byte_last,
  input  logic                   byte_ready,
  output logic                   busy
);

  localparam int unsigned NUM_BYTES = 16;
  localparam int unsigned CNT_W     = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } fsm_t;

  fsm_t               state;
  fsm_t               state_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [127:0]       flat_next;
  logic [127:0]       flat_image;
  logic [CNT_W-1:0]   sel;

  // Column-major flattening: byte k = 4*col + row lands at bits [127-8k -: 8].
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign flat_image[127-8*(4*c+r) -: 8] = state_in[r][c];
    end
  end

  // State, byte counter and captured image.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      flat_out <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      flat_out <= flat_next;
    end
  end

  // Next-state: accept in IDLE, advance the counter on each transfer in STREAM.
  always_comb begin
    state_next = state;
    count_next = count;
    flat_next  = flat_out;
    if (state == IDLE) begin
      if (state_valid) begin
        flat_next  = flat_image;
        count_next = '0;
        state_next = STREAM;
      end
    end else begin
      if (byte_ready) begin
        if (count == LAST_CNT) begin
          count_next = '0;
          state_next = IDLE;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
    end
  end

  // Byte selection; reversal maps counter c to byte 15-c, i.e. bitwise ~c.
  assign sel = (REVERSE_ORDER != 0) ? ~count : count;

  // Outputs depend only on registers (plus reset for state_ready).
  assign busy        = (state == STREAM);
  assign byte_valid  = busy;
  assign byte_last   = busy && (count == LAST_CNT);
  assign byte_data   = busy ? flat_out[{~sel, 3'b111} -: 8] : 8'h00;
  assign state_ready = (state == IDLE) && !reset;

endmodule
